decoder2x4_scan_ctrl: RTL and testbench
=======================================

Name: decoder2x4_scan_ctrl

Overview:
Sequential select generator that drives the A/B select inputs of the 2:4 NAND decoder stage. It steps through the four decoder codes with a programmable dwell, a skip mask, and break-before-make blanking. It supports continuous scan, single sweep, and a one-shot manual code via a valid/ready command. The `active` output qualifies when the decoded one-hot line may be used downstream, for example as a digit/row enable.

Parameters:
- DWELL_W, 8, width of the dwell count input; dwell range 1..2^DWELL_W-1 cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin scan; sampled in IDLE only.
- stop  input  1  abort scan/manual; sampled in SCAN and BLANK.
- mode  input  1  0 = continuous scan, 1 = single sweep; latched at start.
- dwell  input  DWELL_W  cycles each code stays active; latched at start or at command accept.
- en_mask  input  4  bit i=1 enables code i; latched at start.
- cmd_valid  input  1  manual code request.
- cmd_code  input  2  manual code, {A,B}.
- cmd_ready  output  1  command can be accepted.
- A  output  1  decoder select MSB (code bit 1).
- B  output  1  decoder select LSB (code bit 0).
- active  output  1  current code is valid/enabled.
- busy  output  1  not IDLE.
- done  output  1  one-cycle pulse at sweep or manual completion.

Behaviour:
- Code = {A,B}; A is MSB, so code 2 selects Y2 (A & ~B). A and B are registered outputs and never glitch.
- Reset (async, immediate, also mid-operation): state IDLE, A=0, B=0, active=0, busy=0, done=0, all latched fields and the dwell counter cleared.
- Effective dwell D = latched dwell; a latched value of 0 is treated as 1.
- States: IDLE, SCAN, BLANK. Internal flag `manual` distinguishes command runs from scan runs.
- cmd_ready = (state==IDLE) && !start. This is combinational, so start wins when start and cmd_valid are high in the same cycle.
- IDLE:
  - active=0, busy=0; A/B hold their last value.
  - start=1 with en_mask!=0: latch mode, dwell, mask. Code <= lowest enabled index. Go to SCAN.
  - start=1 with en_mask==0: ignored; no state change, no done.
  - cmd_valid && cmd_ready: code <= cmd_code, latch dwell, manual=1, go to SCAN. en_mask is not used for manual runs.
- SCAN:
  - active=1, busy=1. Remains for exactly D cycles; the counter loads at entry.
  - Latency: start or accept at edge k gives new A/B and active=1 visible after edge k, for D cycles.
- Exit from SCAN at dwell expiry:
  - manual=1: go to IDLE, done=1 for one cycle, manual cleared, code held.
  - Otherwise, compute next = next enabled index above current, wrapping 3→0.
  - mode=1 and next <= current (wrapped past the highest enabled code): go to IDLE, done=1, code held.
  - Otherwise go to BLANK.
- BLANK:
  - Exactly 1 cycle, active=0, busy=1. Code <= next at the BLANK entry edge, so A/B only change while active=0.
  - Then return to SCAN.
  - Per-code period in a scan is D+1 cycles.
  - Single enabled code in continuous mode: next == current. Still passes through BLANK; code is unchanged.
- stop=1 in SCAN or BLANK:
  - Next state IDLE, active=0, busy=0, done not pulsed, code held.
  - Priority: stop > dwell expiry > everything else.
- Changes on en_mask, mode, or dwell while busy have no effect until the next start or command.
- start while busy is ignored. cmd_valid while busy waits, because cmd_ready=0.

Test Plan:
- Reset, then idle: after rst_n deassert → A=B=0, active=0, busy=0, cmd_ready=1; asserting rst_n low mid-SCAN clears all outputs without waiting for a clock.
- Continuous scan: mode=0, dwell=3, en_mask=4'b1111, start pulse → codes 0,1,2,3,0… each with active high for 3 cycles then 1 blank cycle; A/B never change while active=1.
- Single sweep with skip: mode=1, dwell=2, en_mask=4'b1010 → code 1 (2 cycles), blank, code 3 (2 cycles), done pulse the next cycle, busy=0, A/B stay at 3.
- Manual command: in IDLE, cmd_valid=1, cmd_code=2, dwell=0 → accepted that cycle; A=1, B=0, active=1 for exactly 1 cycle, then done=1, cmd_ready=1.
- Collision and mask edge: start and cmd_valid high in the same IDLE cycle → cmd_ready=0, scan starts. start with en_mask=0 → no state change, no done.
- Stop: stop=1 on the 2nd cycle of a dwell=5 SCAN at code 1 → next cycle IDLE, active=0, done=0, A/B remain at code 1.

Source files
------------

// File: rtl/decoder2x4_scan_ctrl_if.sv
// Control/status bundle between a scan master and the 2:4 decoder select
// generator. The master drives scan and command requests; the slave (the
// controller) returns the decoder selects and status flags.
interface decoder2x4_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         en_mask;
  logic               cmd_valid;
  logic [1:0]         cmd_code;
  logic               cmd_ready;
  logic               A;
  logic               B;
  logic               active;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, dwell, en_mask, cmd_valid, cmd_code,
    input  cmd_ready, A, B, active, busy, done
  );

  modport slave (
    input  start, stop, mode, dwell, en_mask, cmd_valid, cmd_code,
    output cmd_ready, A, B, active, busy, done
  );
endinterface

// File: rtl/decoder2x4_scan_ctrl.sv
// Select generator for a 2:4 NAND decoder stage. Steps {A,B} through the
// enabled codes with a programmable dwell, inserting one blanking cycle
// between codes so the selects only move while the decoded line is unused.
// Also runs a single manual code on a valid/ready command.
module decoder2x4_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  decoder2x4_scan_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_BLANK
  } state_t;

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  state_t             r_state,  w_state_nxt;
  logic [1:0]         r_code,   w_code_nxt;
  logic [DWELL_W-1:0] r_cnt,    w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
  logic [3:0]         r_mask,   w_mask_nxt;
  logic               r_mode,   w_mode_nxt;
  logic               r_manual, w_manual_nxt;
  logic               r_done,   w_done_nxt;
  logic               w_cmd_ready;
  logic [1:0]         w_next_code;

  // A dwell of zero behaves as a one-cycle dwell.
  function automatic logic [DWELL_W-1:0] f_eff_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  // Lowest enabled code; only called with a non-zero mask.
  function automatic logic [1:0] f_lowest(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  // Next enabled code above cur, wrapping 3->0; cur itself if it is the only one.
  function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] idx;
    logic       found;
    f_next = cur;
    found  = 1'b0;
    for (int i = 1; i < 4; i++) begin
      idx = cur + 2'(i);
      if (!found && mask[idx]) begin
        f_next = idx;
        found  = 1'b1;
      end
    end
  endfunction

  assign w_cmd_ready = (r_state == S_IDLE) && !bus.start;
  assign w_next_code = f_next(r_code, r_mask);

  // Next-state and datapath decisions for the scan/blank/manual sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_cnt_nxt    = r_cnt;
    w_dwell_nxt  = r_dwell;
    w_mask_nxt   = r_mask;
    w_mode_nxt   = r_mode;
    w_manual_nxt = r_manual;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.en_mask != 4'b0000)) begin
          w_mode_nxt   = bus.mode;
          w_dwell_nxt  = bus.dwell;
          w_mask_nxt   = bus.en_mask;
          w_code_nxt   = f_lowest(bus.en_mask);
          w_cnt_nxt    = f_eff_dwell(bus.dwell);
          w_manual_nxt = 1'b0;
          w_state_nxt  = S_SCAN;
        end else if (bus.cmd_valid && w_cmd_ready) begin
          w_dwell_nxt  = bus.dwell;
          w_code_nxt   = bus.cmd_code;
          w_cnt_nxt    = f_eff_dwell(bus.dwell);
          w_manual_nxt = 1'b1;
          w_state_nxt  = S_SCAN;
        end
      end

      S_SCAN: begin
        if (bus.stop) begin
          w_manual_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (r_cnt <= ONE) begin
          if (r_manual) begin
            w_manual_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
          end else if (r_mode && (w_next_code <= r_code)) begin
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            // Selects move on entry to BLANK, while the line is inactive.
            w_code_nxt   = w_next_code;
            w_state_nxt  = S_BLANK;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end

      S_BLANK: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = f_eff_dwell(r_dwell);
          w_state_nxt = S_SCAN;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every latched field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_code   <= 2'd0;
      r_cnt    <= '0;
      r_dwell  <= '0;
      r_mask   <= 4'b0000;
      r_mode   <= 1'b0;
      r_manual <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dwell  <= w_dwell_nxt;
      r_mask   <= w_mask_nxt;
      r_mode   <= w_mode_nxt;
      r_manual <= w_manual_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.A         = r_code[1];
  assign bus.B         = r_code[0];
  assign bus.active    = (r_state == S_SCAN);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_decoder2x4_scan_ctrl.sv
// Bench for decoder2x4_scan_ctrl: table of single-step vectors, directed
// multi-cycle sequences, and randomized runs against a trace model that
// expands a scan or command into its expected per-cycle output sequence.
module tb_decoder2x4_scan_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder2x4_scan_ctrl_if #(.DWELL_W(DW)) bus ();

  decoder2x4_scan_ctrl #(.DWELL_W(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] code;
    logic       active;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic          start;
    logic          cmd_valid;
    logic [1:0]    cmd_code;
    logic [3:0]    mask;
    logic          exp_ready;
    logic [1:0]    exp_code;
    logic          exp_active;
    logic          exp_busy;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode      = 1'b0;
    bus.dwell     = '0;
    bus.en_mask   = 4'b0000;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'd0;
  endtask

  function automatic logic [31:0] dut_code();
    return 32'({bus.A, bus.B});
  endfunction

  function automatic logic [31:0] dut_status();
    return 32'({bus.active, bus.busy, bus.done});
  endfunction

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic exp_t mk(input int code, input bit act, input bit bsy, input bit dn);
    exp_t e;
    e.code   = 2'(code);
    e.active = act;
    e.busy   = bsy;
    e.done   = dn;
    return e;
  endfunction

  // Expected trace of a scan: each enabled code in ascending order shown for
  // D active cycles, a blank cycle (already showing the next code) between
  // codes; single sweep ends with a done cycle, continuous repeats.
  task automatic build_scan(input bit mode, input int dwell, input logic [3:0] mask, input int n);
    int codes[$];
    int d;
    int k;
    q.delete();
    for (int i = 0; i < 4; i++) if (mask[i]) codes.push_back(i);
    d = eff(dwell);
    if (mode) begin
      foreach (codes[j]) begin
        if (j > 0) q.push_back(mk(codes[j], 0, 1, 0));
        repeat (d) q.push_back(mk(codes[j], 1, 1, 0));
      end
      q.push_back(mk(codes[codes.size()-1], 0, 0, 1));
      repeat (2) q.push_back(mk(codes[codes.size()-1], 0, 0, 0));
    end else begin
      k = 0;
      while (q.size() < n) begin
        if (k > 0) q.push_back(mk(codes[k % codes.size()], 0, 1, 0));
        repeat (d) q.push_back(mk(codes[k % codes.size()], 1, 1, 0));
        k++;
      end
    end
  endtask

  task automatic build_manual(input int code, input int dwell);
    q.delete();
    repeat (eff(dwell)) q.push_back(mk(code, 1, 1, 0));
    q.push_back(mk(code, 0, 0, 1));
    repeat (2) q.push_back(mk(code, 0, 0, 0));
  endtask

  // Walk the expected trace one cycle at a time. Config inputs are scrambled
  // every cycle (they must not matter once latched); start/cmd_valid are
  // only wiggled while busy, where they must be ignored.
  task automatic play(input string tag);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) tick();
      check({tag, " code"}, dut_code(), 32'(q[i].code));
      check({tag, " act/busy/done"}, dut_status(), 32'({q[i].active, q[i].busy, q[i].done}));
      bus.en_mask  = 4'($urandom);
      bus.dwell    = DW'($urandom);
      bus.mode     = 1'($urandom);
      bus.cmd_code = 2'($urandom);
      if (q[i].busy) begin
        bus.start     = 1'($urandom);
        bus.cmd_valid = 1'($urandom);
      end else begin
        bus.start     = 1'b0;
        bus.cmd_valid = 1'b0;
      end
      #1;
      check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'(!q[i].busy && !bus.start));
    end
  endtask

  // Stop whatever is running; selects must hold the last shown code.
  task automatic stop_and_check(input string tag);
    logic [1:0] last;
    last          = q[q.size()-1].code;
    bus.start     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.stop      = 1'b1;
    tick();
    bus.stop      = 1'b0;
    check({tag, " stop code"}, dut_code(), 32'(last));
    check({tag, " stop status"}, dut_status(), 32'b000);
  endtask

  task automatic run_scan(input string tag, input bit mode, input int dwell,
                          input logic [3:0] mask, input int n);
    build_scan(mode, dwell, mask, n);
    idle_inputs();
    bus.mode    = mode;
    bus.dwell   = DW'(dwell);
    bus.en_mask = mask;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    play(tag);
    stop_and_check(tag);
  endtask

  task automatic run_manual(input string tag, input int code, input int dwell);
    build_manual(code, dwell);
    idle_inputs();
    bus.cmd_code  = 2'(code);
    bus.dwell     = DW'(dwell);
    bus.cmd_valid = 1'b1;
    #1;
    check({tag, " accept ready"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    play(tag);
    stop_and_check(tag);
  endtask

  vec_t vecs[8];

  initial begin
    // start, cmd_valid, cmd_code, mask, exp_ready, exp_code, exp_active, exp_busy
    vecs[0] = '{1'b1, 1'b0, 2'd0, 4'b1111, 1'b0, 2'd0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 4'b1010, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 4'b1000, 1'b0, 2'd3, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b1};

    // Reset and idle state.
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset code", dut_code(), 32'd0);
    check("reset status", dut_status(), 32'b000);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    check("idle status", dut_status(), 32'b000);

    // Single-step vectors from IDLE, each aborted with stop.
    for (int v = 0; v < 8; v++) begin
      idle_inputs();
      bus.start     = vecs[v].start;
      bus.cmd_valid = vecs[v].cmd_valid;
      bus.cmd_code  = vecs[v].cmd_code;
      bus.en_mask   = vecs[v].mask;
      bus.dwell     = DW'(5);
      #1;
      check($sformatf("vec%0d cmd_ready", v), 32'(bus.cmd_ready), 32'(vecs[v].exp_ready));
      tick();
      bus.start     = 1'b0;
      bus.cmd_valid = 1'b0;
      check($sformatf("vec%0d code", v), dut_code(), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d act/busy/done", v), dut_status(),
            32'({vecs[v].exp_active, vecs[v].exp_busy, 1'b0}));
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check($sformatf("vec%0d after stop code", v), dut_code(), 32'(vecs[v].exp_code));
      check($sformatf("vec%0d after stop status", v), dut_status(), 32'b000);
    end

    // Directed multi-cycle sequences.
    run_scan("cont 1111 d3", 1'b0, 3, 4'b1111, 24);
    run_scan("sweep 1010 d2", 1'b1, 2, 4'b1010, 0);
    run_scan("cont single d2", 1'b0, 2, 4'b0100, 10);
    run_scan("sweep single d0", 1'b1, 0, 4'b0001, 0);
    run_manual("manual c2 d0", 2, 0);
    run_scan("sweep max d255", 1'b1, 255, 4'b0001, 0);

    // Stop on the second cycle of a dwell-5 scan at code 1.
    idle_inputs();
    bus.dwell   = DW'(5);
    bus.en_mask = 4'b0010;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check("stop seq first code", dut_code(), 32'd1);
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop seq code held", dut_code(), 32'd1);
    check("stop seq status", dut_status(), 32'b000);
    tick();
    check("stop seq no late done", dut_status(), 32'b000);

    // Randomized scans and commands.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        run_manual($sformatf("rnd%0d manual", it), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)));
      else
        run_scan($sformatf("rnd%0d scan", it), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4)), 4'($urandom_range(1, 15)),
                 int'($urandom_range(8, 30)));
    end

    // Asynchronous reset in the middle of a scan at code 3.
    idle_inputs();
    bus.dwell   = DW'(3);
    bus.en_mask = 4'b1000;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check("pre-reset code", dut_code(), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async reset code", dut_code(), 32'd0);
    check("async reset status", dut_status(), 32'b000);
    check("async reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset status", dut_status(), 32'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
